// File: rtl/id_ex_alu_ctrl.sv
// ID->EX pipeline register with MIPS ALU-control decode.
// Decodes the ID-stage instruction combinationally and registers operands and control for EX.
module id_ex_alu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_id,
    input  logic [31:0]      instr_id,
    input  logic [WIDTH-1:0] rdata1_id,
    input  logic [WIDTH-1:0] rdata2_id,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] val1_exe,
    output logic [WIDTH-1:0] val2_exe,
    output logic [4:0]       shamt_exe,
    output logic [3:0]       alucontrol_exe,
    output logic             regwrite_exe,
    output logic             memread_exe,
    output logic             memwrite_exe,
    output logic             valid_exe,
    output logic             illegal_exe,
    output logic [4:0]       dest_exe
);

    localparam logic [3:0] EXE_ADD          = 4'b0000;
    localparam logic [3:0] EXE_AND          = 4'b0001;
    localparam logic [3:0] EXE_SUB          = 4'b0010;
    localparam logic [3:0] EXE_OR           = 4'b0011;
    localparam logic [3:0] EXE_SLT          = 4'b0100;
    localparam logic [3:0] EXE_NOR          = 4'b0101;
    localparam logic [3:0] EXE_SLL          = 4'b0110;
    localparam logic [3:0] EXE_SRL          = 4'b0111;
    localparam logic [3:0] EXE_NO_OPERATION = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt_field;

    assign opcode      = instr_id[31:26];
    assign funct       = instr_id[5:0];
    assign rt          = instr_id[20:16];
    assign rd          = instr_id[15:11];
    assign shamt_field = instr_id[10:6];

    logic [WIDTH-1:0] sext_imm;
    logic [WIDTH-1:0] zext_imm;

    assign sext_imm = {{(WIDTH-16){instr_id[15]}}, instr_id[15:0]};
    assign zext_imm = {{(WIDTH-16){1'b0}}, instr_id[15:0]};

    // Raw decode, before validity and illegal-instruction masking.
    logic             legal;
    logic [3:0]       dec_alu;
    logic [WIDTH-1:0] dec_val1;
    logic [WIDTH-1:0] dec_val2;
    logic [4:0]       dec_shamt;
    logic [4:0]       dec_dest;
    logic             dec_write;
    logic             dec_memread;
    logic             dec_memwrite;

    always_comb begin
        legal        = 1'b1;
        dec_alu      = EXE_NO_OPERATION;
        dec_val1     = rdata1_id;
        dec_val2     = rdata2_id;
        dec_shamt    = 5'd0;
        dec_dest     = 5'd0;
        dec_write    = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                dec_dest  = rd;
                dec_write = 1'b1;
                unique case (funct)
                    FN_ADD, FN_ADDU: dec_alu = EXE_ADD;
                    FN_SUB, FN_SUBU: dec_alu = EXE_SUB;
                    FN_AND:          dec_alu = EXE_AND;
                    FN_OR:           dec_alu = EXE_OR;
                    FN_NOR:          dec_alu = EXE_NOR;
                    FN_SLT:          dec_alu = EXE_SLT;
                    FN_SLL, FN_SRL: begin
                        dec_alu   = (funct == FN_SLL) ? EXE_SLL : EXE_SRL;
                        dec_val1  = rdata2_id;
                        dec_val2  = '0;
                        dec_shamt = shamt_field;
                    end
                    default:         legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                dec_alu   = (opcode == OP_ADDI) ? EXE_ADD : EXE_SLT;
                dec_val2  = sext_imm;
                dec_dest  = rt;
                dec_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_alu   = (opcode == OP_ANDI) ? EXE_AND : EXE_OR;
                dec_val2  = zext_imm;
                dec_dest  = rt;
                dec_write = 1'b1;
            end
            OP_LW: begin
                dec_alu     = EXE_ADD;
                dec_val2    = sext_imm;
                dec_dest    = rt;
                dec_write   = 1'b1;
                dec_memread = 1'b1;
            end
            OP_SW: begin
                dec_alu      = EXE_ADD;
                dec_val2     = sext_imm;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_alu = EXE_SUB;
            end
            default: legal = 1'b0;
        endcase
    end

    // Masked next-state: bubble when invalid, control-free but flagged when illegal.
    logic [WIDTH-1:0] val1_d;
    logic [WIDTH-1:0] val2_d;
    logic [4:0]       shamt_d;
    logic [3:0]       alu_d;
    logic             regwrite_d;
    logic             memread_d;
    logic             memwrite_d;
    logic             valid_d;
    logic             illegal_d;
    logic [4:0]       dest_d;

    always_comb begin
        val1_d     = '0;
        val2_d     = '0;
        shamt_d    = 5'd0;
        alu_d      = EXE_NO_OPERATION;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        valid_d    = valid_id;
        illegal_d  = 1'b0;
        dest_d     = 5'd0;

        if (valid_id) begin
            if (legal) begin
                val1_d     = dec_val1;
                val2_d     = dec_val2;
                shamt_d    = dec_shamt;
                alu_d      = dec_alu;
                // Writes to $0 are architecturally dead, including the all-zero NOP.
                regwrite_d = dec_write && (dec_dest != 5'd0);
                memread_d  = dec_memread;
                memwrite_d = dec_memwrite;
                dest_d     = dec_dest;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val1_exe       <= '0;
            val2_exe       <= '0;
            shamt_exe      <= 5'd0;
            alucontrol_exe <= EXE_NO_OPERATION;
            regwrite_exe   <= 1'b0;
            memread_exe    <= 1'b0;
            memwrite_exe   <= 1'b0;
            valid_exe      <= 1'b0;
            illegal_exe    <= 1'b0;
            dest_exe       <= 5'd0;
        end else if (flush) begin
            val1_exe       <= '0;
            val2_exe       <= '0;
            shamt_exe      <= 5'd0;
            alucontrol_exe <= EXE_NO_OPERATION;
            regwrite_exe   <= 1'b0;
            memread_exe    <= 1'b0;
            memwrite_exe   <= 1'b0;
            valid_exe      <= 1'b0;
            illegal_exe    <= 1'b0;
            dest_exe       <= 5'd0;
        end else if (!stall) begin
            val1_exe       <= val1_d;
            val2_exe       <= val2_d;
            shamt_exe      <= shamt_d;
            alucontrol_exe <= alu_d;
            regwrite_exe   <= regwrite_d;
            memread_exe    <= memread_d;
            memwrite_exe   <= memwrite_d;
            valid_exe      <= valid_d;
            illegal_exe    <= illegal_d;
            dest_exe       <= dest_d;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Scoreboard bench for id_ex_alu_ctrl: driver pushes model predictions, monitor pops and compares.
module tb_id_ex_alu_ctrl;

    typedef struct packed {
        logic [31:0] val1;
        logic [31:0] val2;
        logic [4:0]  shamt;
        logic [3:0]  alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        v;
        logic        ill;
        logic [4:0]  dest;
    } exp_t;

    localparam exp_t BUBBLE = '{val1: 32'd0, val2: 32'd0, shamt: 5'd0, alu: 4'hF,
                                rw: 1'b0, mr: 1'b0, mw: 1'b0, v: 1'b0, ill: 1'b0, dest: 5'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_id = 1'b0;
    logic [31:0] instr_id = 32'd0;
    logic [31:0] rdata1_id = 32'd0;
    logic [31:0] rdata2_id = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] val1_exe;
    logic [31:0] val2_exe;
    logic [4:0]  shamt_exe;
    logic [3:0]  alucontrol_exe;
    logic        regwrite_exe;
    logic        memread_exe;
    logic        memwrite_exe;
    logic        valid_exe;
    logic        illegal_exe;
    logic [4:0]  dest_exe;

    id_ex_alu_ctrl #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_id       (valid_id),
        .instr_id       (instr_id),
        .rdata1_id      (rdata1_id),
        .rdata2_id      (rdata2_id),
        .stall          (stall),
        .flush          (flush),
        .val1_exe       (val1_exe),
        .val2_exe       (val2_exe),
        .shamt_exe      (shamt_exe),
        .alucontrol_exe (alucontrol_exe),
        .regwrite_exe   (regwrite_exe),
        .memread_exe    (memread_exe),
        .memwrite_exe   (memwrite_exe),
        .valid_exe      (valid_exe),
        .illegal_exe    (illegal_exe),
        .dest_exe       (dest_exe)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur = BUBBLE;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic exp_t observed();
        exp_t o;
        o.val1  = val1_exe;
        o.val2  = val2_exe;
        o.shamt = shamt_exe;
        o.alu   = alucontrol_exe;
        o.rw    = regwrite_exe;
        o.mr    = memread_exe;
        o.mw    = memwrite_exe;
        o.v     = valid_exe;
        o.ill   = illegal_exe;
        o.dest  = dest_exe;
        return o;
    endfunction

    task automatic compare(input string nm, input exp_t want);
        exp_t got = observed();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got val1=%h val2=%h sh=%0d alu=%b rw=%b mr=%b mw=%b v=%b ill=%b dest=%0d | want val1=%h val2=%h sh=%0d alu=%b rw=%b mr=%b mw=%b v=%b ill=%b dest=%0d",
                     nm, got.val1, got.val2, got.shamt, got.alu, got.rw, got.mr, got.mw, got.v,
                     got.ill, got.dest, want.val1, want.val2, want.shamt, want.alu, want.rw,
                     want.mr, want.mw, want.v, want.ill, want.dest);
        end
    endtask

    // Reference: classify the instruction by mnemonic, then derive every field from that.
    function automatic exp_t model(input logic v, input logic [31:0] ins,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t  e = BUBBLE;
        string m = "illegal";
        logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zx = {16'd0, ins[15:0]};
        if (!v) return e;
        e.v = 1'b1;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20, 6'h21: m = "add";
                6'h22, 6'h23: m = "sub";
                6'h24: m = "and";
                6'h25: m = "or";
                6'h27: m = "nor";
                6'h2A: m = "slt";
                6'h00: m = "sll";
                6'h02: m = "srl";
                default: m = "illegal";
            endcase
        end else begin
            case (ins[31:26])
                6'h08: m = "addi";
                6'h0A: m = "slti";
                6'h0C: m = "andi";
                6'h0D: m = "ori";
                6'h23: m = "lw";
                6'h2B: m = "sw";
                6'h04: m = "beq";
                default: m = "illegal";
            endcase
        end
        if (m == "illegal") begin
            e.ill = 1'b1;
            return e;
        end
        if (m == "add" || m == "sub" || m == "and" || m == "or" || m == "nor" || m == "slt") begin
            e.alu  = (m == "add") ? 4'd0 : (m == "and") ? 4'd1 : (m == "sub") ? 4'd2 :
                     (m == "or")  ? 4'd3 : (m == "slt") ? 4'd4 : 4'd5;
            e.val1 = a; e.val2 = b; e.dest = ins[15:11]; e.rw = 1'b1;
        end else if (m == "sll" || m == "srl") begin
            e.alu  = (m == "sll") ? 4'd6 : 4'd7;
            e.val1 = b; e.val2 = 0; e.shamt = ins[10:6]; e.dest = ins[15:11]; e.rw = 1'b1;
        end else if (m == "beq") begin
            e.alu = 4'd2; e.val1 = a; e.val2 = b;
        end else begin
            e.val1 = a;
            e.val2 = (m == "andi" || m == "ori") ? zx : sx;
            e.alu  = (m == "slti") ? 4'd4 : (m == "andi") ? 4'd1 : (m == "ori") ? 4'd3 : 4'd0;
            e.mr   = (m == "lw");
            e.mw   = (m == "sw");
            e.rw   = (m != "sw");
            e.dest = (m == "sw") ? 5'd0 : ins[20:16];
        end
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic st, input logic fl, input string nm);
        @(negedge clk);
        rst = 1'b0; valid_id = v; instr_id = ins; rdata1_id = a; rdata2_id = b;
        stall = st; flush = fl;
        if (fl) cur = BUBBLE;
        else if (!st) cur = model(v, ins, a, b);
        exp_q.push_back(cur);
        name_q.push_back(nm);
    endtask

    // Asynchronous reset between edges, with stall asserted to show reset overrides it.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        #1;
        compare(nm, BUBBLE);
        cur = BUBBLE;
        exp_q.push_back(cur);
        name_q.push_back({nm, "_held"});
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin : driver
        logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                                 6'h23, 6'h2B, 6'h04, 6'h3F};
        logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                                 6'h2A, 6'h00, 6'h02};
        logic [31:0] ins;
        repeat (2) @(negedge clk);
        compare("reset_init", BUBBLE);

        step(1, 32'h01095020, 32'd5, 32'd7, 0, 0, "add_r");
        step(1, 32'h2128FFFF, 32'd11, 32'd0, 0, 0, "addi_neg");
        step(1, 32'h3528FFFF, 32'd11, 32'd0, 0, 0, "ori_zext");
        step(1, 32'h00094100, 32'd9, 32'd3, 0, 0, "sll");
        step(1, 32'h00000000, 32'd1, 32'd2, 0, 0, "nop");
        step(1, 32'h01095020, 32'd5, 32'd7, 0, 0, "add_before_stall");
        step(1, 32'h2128FFFF, 32'd1, 32'd2, 1, 0, "stall1");
        step(1, 32'hFC000000, 32'd3, 32'd4, 1, 0, "stall2");
        step(0, 32'h00094100, 32'd5, 32'd6, 1, 0, "stall3");
        step(1, 32'h01095020, 32'd5, 32'd7, 1, 1, "stall_flush");
        step(1, 32'hFC000000, 32'd5, 32'd7, 0, 0, "illegal_op");
        step(1, 32'hAD280004, 32'd100, 32'd9, 0, 0, "sw");
        step(1, 32'h8D280010, 32'd100, 32'd9, 0, 0, "lw");
        step(1, 32'h11090003, 32'd8, 32'd8, 0, 0, "beq");
        step(0, 32'h01095020, 32'd5, 32'd7, 0, 0, "invalid_bubble");
        step(1, 32'h01095020, 32'd5, 32'd7, 0, 0, "add_pre_reset");
        async_reset("async_reset");
        step(1, 32'h2128FFFF, 32'd1, 32'd2, 0, 0, "after_reset");

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(10, 0)];
            if ($urandom_range(3, 0) != 0) ins[5:0] = fns[$urandom_range(9, 0)];
            if ($urandom_range(19, 0) == 0) ins[31:26] = 6'($urandom);
            if (i % 97 == 50) begin
                step(1, ins, $urandom, $urandom, 0, 0, "rand_pre_reset");
                async_reset("rand_async_reset");
            end else begin
                step($urandom_range(19, 0) != 0, ins, $urandom, $urandom,
                     $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0, "random");
            end
        end

        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
